lsu_arbiter: RTL

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin arbiter between a fetch and a data port onto one LSU.
// Define LSU_ARB_SPLIT_EN to split misaligned data words into two byte accesses.
module lsu_arbiter (
   input  logic        clk,
   input  logic        a_rst,
   input  logic        f_req,
   input  logic [15:0] f_addr,
   output logic        f_ack,
   output logic        f_done,
   output logic [15:0] f_rdata,
   input  logic        d_req,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   input  logic        d_cmd,
   input  logic        d_width,
   output logic        d_ack,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic [15:0] lsu_addr,
   output logic [15:0] lsu_data,
   output logic        lsu_cmd,
   output logic        lsu_width,
   output logic        lsu_t_id,
   output logic        lsu_start,
   output logic        lsu_wr_addr,
   input  logic        lsu_ack,
   input  logic        lsu_busy,
   input  logic        mem_rdy,
   input  logic [15:0] mem_rdata
);

`ifdef LSU_ARB_SPLIT_EN
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ISSUE_HI, WAIT_HI} state_t;
`else
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

   state_t      state;
   state_t      nxt;
   logic        grant;
   logic        grant_d;
   logic        cap;
   logic        last_d;
   logic        f_vld;
   logic        d_vld;
   logic [15:0] r_addr;
   logic [15:0] r_data;
   logic        r_cmd;
   logic        r_width;
   logic        r_tid;
   logic [15:0] f_rq;
   logic [15:0] d_rq;
   logic [15:0] rd_val;
   logic [7:0]  mem_byte;
`ifdef LSU_ARB_SPLIT_EN
   logic        cap_lo;
   logic        r_split;
   logic [7:0]  r_hi;
   logic [7:0]  r_lo;
   logic        mis;
   assign mis = ~d_width & d_addr[0];
`endif

   assign lsu_addr    = r_addr;
   assign lsu_data    = r_data;
   assign lsu_cmd     = r_cmd;
   assign lsu_width   = r_width;
   assign lsu_t_id    = r_tid;
   assign lsu_wr_addr = 1'b1;
   assign f_rdata     = f_vld ? f_rq : 16'h0000;
   assign d_rdata     = d_vld ? d_rq : 16'h0000;
   assign mem_byte    = r_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];

   // Read result: byte lane select, zero-extend, or reassembled split word
   always_comb begin
      rd_val = r_width ? {8'h00, mem_byte} : mem_rdata;
`ifdef LSU_ARB_SPLIT_EN
      if (r_split) rd_val = {mem_byte, r_lo};
`endif
   end

   // State register
   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) state <= IDLE;
      else        state <= nxt;
   end

   // Next state, grant and LSU handshake
   always_comb begin
      nxt       = state;
      grant     = 1'b0;
      grant_d   = 1'b0;
      f_ack     = 1'b0;
      d_ack     = 1'b0;
      lsu_start = 1'b0;
      cap       = 1'b0;
`ifdef LSU_ARB_SPLIT_EN
      cap_lo    = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (a_rst && (f_req || d_req)) begin
               grant   = 1'b1;
               grant_d = d_req & (~f_req | ~last_d);
               f_ack   = ~grant_d;
               d_ack   = grant_d;
               nxt     = ISSUE;
            end
         end
         ISSUE: begin
            lsu_start = 1'b1;
            if (lsu_ack) nxt = WAIT;
         end
         WAIT: begin
            if (mem_rdy && lsu_busy) begin
               nxt = IDLE;
               cap = 1'b1;
`ifdef LSU_ARB_SPLIT_EN
               if (r_split) begin
                  nxt    = ISSUE_HI;
                  cap    = 1'b0;
                  cap_lo = 1'b1;
               end
`endif
            end
         end
`ifdef LSU_ARB_SPLIT_EN
         ISSUE_HI: begin
            lsu_start = 1'b1;
            if (lsu_ack) nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (mem_rdy && lsu_busy) begin
               nxt = IDLE;
               cap = 1'b1;
            end
         end
`endif
         default: nxt = IDLE;
      endcase
   end

   // Done pulses, rdata-valid flags and round-robin pointer
   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         f_done <= 1'b0;
         d_done <= 1'b0;
         f_vld  <= 1'b0;
         d_vld  <= 1'b0;
         last_d <= 1'b1;
      end else begin
         f_done <= cap & ~r_tid;
         d_done <= cap & r_tid;
         if (cap && !r_cmd) begin
            if (r_tid) d_vld <= 1'b1;
            else       f_vld <= 1'b1;
         end
         if (grant) last_d <= grant_d;
      end
   end

   // Request fields and read data; no reset needed on the datapath
   always_ff @(posedge clk) begin
      if (grant) begin
         r_tid <= grant_d;
         if (grant_d) begin
            r_addr  <= d_addr;
            r_cmd   <= d_cmd;
            r_width <= d_width;
            r_data  <= d_width ? {2{d_wdata[7:0]}} : d_wdata;
`ifdef LSU_ARB_SPLIT_EN
            r_split <= mis;
            r_hi    <= d_wdata[15:8];
            if (mis) begin
               r_width <= 1'b1;
               r_data  <= {2{d_wdata[7:0]}};
            end
`endif
         end else begin
            r_addr  <= f_addr;
            r_cmd   <= 1'b0;
            r_width <= 1'b0;
            r_data  <= 16'h0000;
`ifdef LSU_ARB_SPLIT_EN
            r_split <= 1'b0;
`endif
         end
      end
`ifdef LSU_ARB_SPLIT_EN
      if (cap_lo) begin
         r_lo   <= mem_byte;
         r_addr <= r_addr + 16'd1;
         r_data <= {2{r_hi}};
      end
`endif
      if (cap && !r_cmd) begin
         if (r_tid) d_rq <= rd_val;
         else       f_rq <= rd_val;
      end
   end

endmodule
